// File: rtl/vproc_sld_wb_pkg.sv
// ============================================================================
// vproc_sld_wb_pkg : shared types and helpers for the slide writeback stage
// Rev 1.0
// ============================================================================
`default_nettype none

package vproc_sld_wb_pkg;

  localparam int unsigned SLD_WB_ADDR_W = 5;

  typedef enum logic [0:0] {
    SLD_WB_ACCUM = 1'b0,
    SLD_WB_WRITE = 1'b1
  } sld_wb_state_e;

  function automatic int unsigned SLD_WB_BEATS(input int unsigned vreg_w,
                                               input int unsigned sld_op_w);
    return vreg_w / sld_op_w;
  endfunction

  // Slot index width; a single-beat register still needs a 1-bit index.
  function automatic int unsigned SLD_WB_IDX_W(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vproc_sld_wb_if.sv
// ============================================================================
// vproc_sld_wb_if : slide result beat stream in, vector register write out
// Rev 1.0
// ============================================================================
`default_nettype none

interface vproc_sld_wb_if #(
  parameter int unsigned VREG_W   = 128,
  parameter int unsigned SLD_OP_W = 64
);

  logic                    pipe_in_valid;
  logic                    pipe_in_ready;
  logic [SLD_OP_W-1:0]     pipe_in_res;
  logic [SLD_OP_W/8-1:0]   pipe_in_mask;
  logic [4:0]              pipe_in_vaddr;
  logic                    pipe_in_last;

  logic                    vreg_wr_valid;
  logic                    vreg_wr_ready;
  logic [4:0]              vreg_wr_addr;
  logic [VREG_W-1:0]       vreg_wr_data;
  logic [VREG_W/8-1:0]     vreg_wr_be;

  modport slave (
    input  pipe_in_valid, pipe_in_res, pipe_in_mask, pipe_in_vaddr, pipe_in_last,
    input  vreg_wr_ready,
    output pipe_in_ready,
    output vreg_wr_valid, vreg_wr_addr, vreg_wr_data, vreg_wr_be
  );

  modport master (
    output pipe_in_valid, pipe_in_res, pipe_in_mask, pipe_in_vaddr, pipe_in_last,
    output vreg_wr_ready,
    input  pipe_in_ready,
    input  vreg_wr_valid, vreg_wr_addr, vreg_wr_data, vreg_wr_be
  );

endinterface

`default_nettype wire

// File: rtl/vproc_sld_wb.sv
// ============================================================================
// vproc_sld_wb : assembles slide result beats into full vector register writes
// Optional macro VPROC_SLD_WB_OVERLAP_EN accepts a beat during the write handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

module vproc_sld_wb
  import vproc_sld_wb_pkg::*;
#(
  parameter int unsigned VREG_W         = 128,
  parameter int unsigned SLD_OP_W       = 64,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic          clk_i,
  input  logic          async_rst_i,
  vproc_sld_wb_if.slave bus,
  output logic          busy_o
);

  localparam int unsigned N      = SLD_WB_BEATS(VREG_W, SLD_OP_W);
  localparam int unsigned IDX_W  = SLD_WB_IDX_W(N);
  localparam int unsigned BEAT_B = SLD_OP_W / 8;

  sld_wb_state_e                    r_state, w_state_d;
  logic [IDX_W-1:0]                 r_idx, w_idx_d;
  logic                             r_first, w_first_d;
  logic                             r_last, w_last_d;
  logic [SLD_WB_ADDR_W-1:0]         r_addr, w_addr_d;
  logic [N-1:0][BEAT_B-1:0]         r_be, w_be_d;
  logic [N-1:0][SLD_OP_W-1:0]       r_data;
  logic [N-1:0][SLD_OP_W-1:0]       w_data_out;
  logic [N-1:0]                     w_upto;
  logic                             w_slot_we;
  logic [IDX_W-1:0]                 w_slot;
  logic                             w_in_ready;
  logic                             w_accept;
  logic                             w_wr_hs;

`ifdef VPROC_SLD_WB_OVERLAP_EN
  assign w_in_ready = (r_state == SLD_WB_ACCUM) | bus.vreg_wr_ready;
`else
  assign w_in_ready = (r_state == SLD_WB_ACCUM);
`endif

  assign w_accept = bus.pipe_in_valid & w_in_ready;
  assign w_wr_hs  = (r_state == SLD_WB_WRITE) & bus.vreg_wr_ready;

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_first_d = r_first;
    w_last_d  = r_last;
    w_addr_d  = r_addr;
    w_be_d    = r_be;
    w_slot_we = 1'b0;
    w_slot    = r_idx;
    case (r_state)
      SLD_WB_ACCUM: begin
        if (w_accept) begin
          w_slot_we     = 1'b1;
          w_be_d[r_idx] = bus.pipe_in_mask;
          if (r_first) begin
            w_addr_d  = bus.pipe_in_vaddr;
            w_first_d = 1'b0;
          end
          w_last_d = bus.pipe_in_last;
          // idx stays on the final slot so WRITE knows how many slots are valid
          if ((r_idx == IDX_W'(N - 1)) || bus.pipe_in_last) begin
            w_state_d = SLD_WB_WRITE;
          end else begin
            w_idx_d = r_idx + 1'b1;
          end
        end
      end
      SLD_WB_WRITE: begin
        if (w_wr_hs) begin
          w_be_d    = '0;
          w_idx_d   = '0;
          w_state_d = SLD_WB_ACCUM;
          if (r_last) begin
            w_first_d = 1'b1;
          end else begin
            w_addr_d = r_addr + 1'b1;
          end
`ifdef VPROC_SLD_WB_OVERLAP_EN
          if (w_accept) begin
            w_slot_we = 1'b1;
            w_slot    = '0;
            w_be_d[0] = bus.pipe_in_mask;
            w_addr_d  = r_last ? bus.pipe_in_vaddr : (r_addr + 1'b1);
            w_first_d = 1'b0;
            w_last_d  = bus.pipe_in_last;
            if (bus.pipe_in_last || (N == 1)) begin
              w_state_d = SLD_WB_WRITE;
            end else begin
              w_idx_d = IDX_W'(1);
            end
          end
`endif
        end
      end
      default: w_state_d = SLD_WB_ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      r_state <= SLD_WB_ACCUM;
      r_idx   <= '0;
      r_first <= 1'b1;
      r_last  <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_first <= w_first_d;
      r_last  <= w_last_d;
      r_addr  <= w_addr_d;
      r_be    <= w_be_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_slot_we) begin
      r_data[w_slot] <= bus.pipe_in_res;
    end
  end

  // Slots above idx were not written for this register; their data is don't-care.
  always_comb begin
    w_upto = '0;
    for (int i = 0; i < N; i++) begin
      if (i <= int'(r_idx)) begin
        w_upto[i] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    assign w_data_out[gi] = w_upto[gi] ? r_data[gi] : (DONT_CARE_ZERO ? '0 : 'x);
  end

  assign bus.pipe_in_ready = w_in_ready;
  assign bus.vreg_wr_valid = (r_state == SLD_WB_WRITE);
  assign bus.vreg_wr_addr  = r_addr;
  assign bus.vreg_wr_data  = w_data_out;
  assign bus.vreg_wr_be    = r_be;
  assign busy_o            = ~r_first | (r_state == SLD_WB_WRITE);

`ifndef SYNTHESIS
  a_wr_stable: assert property (@(posedge clk_i) disable iff (async_rst_i)
    (bus.vreg_wr_valid && !bus.vreg_wr_ready) |=>
      (bus.vreg_wr_valid && $stable(bus.vreg_wr_addr) &&
       $stable(bus.vreg_wr_data) && $stable(bus.vreg_wr_be)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_vproc_sld_wb.sv
// ============================================================================
// tb_vproc_sld_wb : directed bench with an instruction-level write model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vproc_sld_wb;

  typedef struct {
    logic [4:0]   addr;
    logic [127:0] data;
    logic [15:0]  be;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;

  wr_t          exp_q[$];
  logic [4:0]   addr_log[$];
  logic [4:0]   last_addr;
  logic [127:0] last_data;
  logic [15:0]  last_be;

  logic [63:0] rr [8];
  logic [7:0]  mm [8];

  always #5 clk = ~clk;

  vproc_sld_wb_if #(.VREG_W(128), .SLD_OP_W(64)) bus ();

  vproc_sld_wb #(
    .VREG_W(128),
    .SLD_OP_W(64),
    .DONT_CARE_ZERO(1'b1)
  ) dut (
    .clk_i(clk),
    .async_rst_i(rst),
    .bus(bus),
    .busy_o(busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle a write is offered it must match the oldest outstanding one.
  always @(negedge clk) begin
    if (!rst && bus.vreg_wr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 128'(bus.vreg_wr_addr), 128'h0);
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got a write with no expected entry, expected none");
      end else begin
        chk("wr_addr", 128'(bus.vreg_wr_addr), 128'(exp_q[0].addr));
        chk("wr_data", bus.vreg_wr_data, exp_q[0].data);
        chk("wr_be",   128'(bus.vreg_wr_be), 128'(exp_q[0].be));
        if (bus.vreg_wr_ready) begin
          last_addr = bus.vreg_wr_addr;
          last_data = bus.vreg_wr_data;
          last_be   = bus.vreg_wr_be;
          addr_log.push_back(bus.vreg_wr_addr);
          void'(exp_q.pop_front());
          n_writes++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the beat is taken.
  task automatic send_beat(input logic [63:0] res, input logic [7:0] mask,
                           input logic [4:0] va, input logic last);
    int t;
    bus.pipe_in_valid = 1'b1;
    bus.pipe_in_res   = res;
    bus.pipe_in_mask  = mask;
    bus.pipe_in_vaddr = va;
    bus.pipe_in_last  = last;
    t = 0;
    @(negedge clk);
    while (!bus.pipe_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_accept_timeout: got ready=0 for 100 cycles, expected ready");
    end
    @(posedge clk);
    #1;
    bus.pipe_in_valid = 1'b0;
    bus.pipe_in_last  = 1'b0;
  endtask

  // Model: beats fill 64-bit slots in order, two per register; consecutive
  // registers start at vaddr and wrap at 32; untouched slots are zero/disabled.
  task automatic run_instr(input logic [4:0] vaddr, input int nb,
                           input logic [63:0] res [8], input logic [7:0] msk [8]);
    for (int w = 0; w * 2 < nb; w++) begin
      wr_t e;
      e.addr = 5'(int'(vaddr) + w);
      e.data = '0;
      e.be   = '0;
      for (int s = 0; s < 2; s++) begin
        if (w * 2 + s < nb) begin
          e.data[s*64 +: 64] = res[w*2+s];
          e.be[s*8 +: 8]     = msk[w*2+s];
        end
      end
      exp_q.push_back(e);
    end
    for (int b = 0; b < nb; b++) begin
      send_beat(res[b], msk[b], (b == 0) ? vaddr : ~vaddr, (b == nb - 1));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d writes pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish after 1ms, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] la;
    logic [4:0] lb;
    int w0;
    time t0;
    bus.pipe_in_valid = 1'b0;
    bus.pipe_in_res   = '0;
    bus.pipe_in_mask  = '0;
    bus.pipe_in_vaddr = '0;
    bus.pipe_in_last  = 1'b0;
    bus.vreg_wr_ready = 1'b1;
    rr = '{default: 64'h0};
    mm = '{default: 8'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(bus.vreg_wr_valid), 128'h0);
    chk("rst_busy",  128'(busy), 128'h0);
    chk("rst_ready", 128'(bus.pipe_in_ready), 128'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two beats into one register
    rr[0] = 64'h1111111111111111; rr[1] = 64'h2222222222222222;
    mm[0] = 8'hFF; mm[1] = 8'hFF;
    run_instr(5'd4, 2, rr, mm);
    wait_drain();
    chk("t1_addr", 128'(last_addr), 128'd4);
    chk("t1_data", last_data, 128'h2222222222222222_1111111111111111);
    chk("t1_be",   128'(last_be), 128'hFFFF);
    chk("t1_busy", 128'(busy), 128'h0);

    // LMUL2 group, then the same group wrapping past register 31
    rr[0] = 64'hA0; rr[1] = 64'hA1; rr[2] = 64'hA2; rr[3] = 64'hA3;
    mm[0] = 8'hFF; mm[1] = 8'hF0; mm[2] = 8'h0F; mm[3] = 8'h81;
    run_instr(5'd30, 4, rr, mm);
    wait_drain();
    la = addr_log[addr_log.size()-2];
    lb = addr_log[addr_log.size()-1];
    chk("lmul_addr0", 128'(la), 128'd30);
    chk("lmul_addr1", 128'(lb), 128'd31);
    run_instr(5'd31, 4, rr, mm);
    wait_drain();
    la = addr_log[addr_log.size()-2];
    lb = addr_log[addr_log.size()-1];
    chk("wrap_addr0", 128'(la), 128'd31);
    chk("wrap_addr1", 128'(lb), 128'd0);

    // Single partial beat
    rr[0] = 64'hAAAABBBBCCCCDDDD; mm[0] = 8'h0F;
    run_instr(5'd5, 1, rr, mm);
    wait_drain();
    chk("single_be",   128'(last_be), 128'h000F);
    chk("single_data", last_data, 128'h0000000000000000_AAAABBBBCCCCDDDD);

    // Three beats with a zero-mask beat; last lands in slot 0 of the next register
    rr[0] = 64'h0123456789ABCDEF; rr[1] = 64'hFEDCBA9876543210; rr[2] = 64'h5555AAAA5555AAAA;
    mm[0] = 8'h00; mm[1] = 8'hFF; mm[2] = 8'h0F;
    run_instr(5'd10, 3, rr, mm);
    wait_drain();
    chk("odd_addr", 128'(last_addr), 128'd11);
    chk("odd_be",   128'(last_be), 128'h000F);

    // Register file stalls for 5 cycles while the next beat waits
    bus.vreg_wr_ready = 1'b0;
    rr[0] = 64'hC0C0C0C0C0C0C0C0; rr[1] = 64'hD1D1D1D1D1D1D1D1;
    mm[0] = 8'hFF; mm[1] = 8'h3C;
    run_instr(5'd9, 2, rr, mm);
    w0 = n_writes;
    fork
      begin
        logic [63:0] r2 [8];
        logic [7:0]  m2 [8];
        r2 = '{default: 64'h0};
        m2 = '{default: 8'h0};
        r2[0] = 64'hE2E2E2E2E2E2E2E2; m2[0] = 8'hFF;
        run_instr(5'd12, 1, r2, m2);
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("stall_valid", 128'(bus.vreg_wr_valid), 128'h1);
          chk("stall_ready", 128'(bus.pipe_in_ready), 128'h0);
        end
        @(posedge clk);
        #1;
        bus.vreg_wr_ready = 1'b1;
      end
    join
    wait_drain();
    chk("stall_writes", 128'(n_writes - w0), 128'd2);
    chk("stall_last_addr", 128'(last_addr), 128'd12);

    // Reset while a write is pending
    bus.vreg_wr_ready = 1'b0;
    rr[0] = 64'hFFFFFFFFFFFFFFFF; rr[1] = 64'hFFFFFFFFFFFFFFFF;
    mm[0] = 8'hFF; mm[1] = 8'hFF;
    run_instr(5'd3, 2, rr, mm);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_valid", 128'(bus.vreg_wr_valid), 128'h0);
    chk("rstw_busy",  128'(busy), 128'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.vreg_wr_ready = 1'b1;
    rr[0] = 64'h7777777777777777; mm[0] = 8'h0F;
    run_instr(5'd7, 1, rr, mm);
    wait_drain();
    chk("post_rst_addr", 128'(last_addr), 128'd7);
    chk("post_rst_be",   128'(last_be), 128'h000F);
    chk("post_rst_data", last_data, 128'h0000000000000000_7777777777777777);

    // Continuous stream of four 2-beat instructions
    w0 = n_writes;
    t0 = $time;
    for (int k = 0; k < 4; k++) begin
      rr[0] = 64'(k * 2 + 1); rr[1] = 64'(k * 2 + 2);
      mm[0] = 8'hFF; mm[1] = 8'hFF;
      run_instr(5'(20 + k), 2, rr, mm);
    end
`ifdef VPROC_SLD_WB_OVERLAP_EN
    chk("stream_cycles", 128'(($time - t0) / 10), 128'd8);
`else
    chk("stream_cycles", 128'(($time - t0) / 10), 128'd11);
`endif
    wait_drain();
    chk("stream_writes", 128'(n_writes - w0), 128'd4);
    chk("stream_last", last_data, 128'h0000000000000008_0000000000000007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
